ahb_lite_single_master: RTL
===========================

// Module: ahb_lite_single_master
// PURPOSE
//  AHB-Lite initiator: turns a valid/ready command interface into single AHB-Lite transfers and returns a response.
//  Bus-side counterpart to the memory-mapped peripherals (LED, UART, ...); drives them from a bench or a simple controller.
//  One transfer outstanding at a time, SINGLE bursts only, NONSEQ/IDLE only. Little-endian lane steering for byte/halfword.
// PARAMETERS
//  ALIGN_CHECK  1  1: misaligned or illegal-size commands complete with rsp_error, no bus cycle; 0: issued as-is
// PORTS
//  HCLK        in   1   clock, all logic on rising edge
//  HRESET      in   1   asynchronous, active-high reset
//  cmd_valid   in   1   command present
//  cmd_ready   out  1   block can accept a command (high only in IDLE)
//  cmd_write   in   1   1 = write, 0 = read
//  cmd_addr    in   32  byte address
//  cmd_size    in   3   0 = byte, 1 = half, 2 = word; >2 illegal
//  cmd_wdata   in   32  write data, right-justified (LSBs)
//  rsp_valid   out  1   one-cycle completion pulse
//  rsp_rdata   out  32  read data, right-justified, zero-extended; 0 for writes/errors
//  rsp_error   out  1   valid with rsp_valid: HRESP error or rejected command
//  HADDR       out  32  AHB address
//  HTRANS      out  2   2'b00 IDLE / 2'b10 NONSEQ only
//  HWRITE      out  1   AHB write
//  HSIZE       out  3   AHB size
//  HBURST      out  3   constant 3'b000 (SINGLE)
//  HWDATA      out  32  AHB write data (lane-steered)
//  HRDATA      in   32  AHB read data
//  HREADY      in   1   AHB ready (muxed HREADYOUT)
//  HRESP       in   1   AHB response, 1 = ERROR
// BEHAVIOUR
//  Reset: state IDLE; cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, HADDR=0, HTRANS=IDLE, HWRITE=0, HSIZE=0, HWDATA=0.
//  All outputs registered. FSM states IDLE, ADDR, DATA, RESP.
//  IDLE: on cmd_valid&cmd_ready capture cmd_*. If ALIGN_CHECK and (size>2, size=1 & addr[0], size=2 & addr[1:0]!=0)
//   -> RESP with error=1, no HTRANS activity. Else -> ADDR driving HADDR/HWRITE/HSIZE, HTRANS=NONSEQ next cycle.
//  ADDR: hold all address-phase signals while HREADY=0. Edge with HREADY=1 -> DATA; HTRANS returns to IDLE,
//   HADDR/HWRITE/HSIZE hold last values, HWDATA driven for writes.
//  HWDATA steering: byte -> cmd_wdata[7:0] on lane addr[1:0]; half -> [15:0] on lane addr[1]; word unchanged; other lanes 0.
//  DATA: wait while HREADY=0 (unbounded). HRESP=1 with HREADY=0 is first error cycle: ignore, keep waiting.
//   Edge with HREADY=1 -> RESP; capture HRESP as error; for reads extract lane per addr[1:0]/size, zero-extend.
//  RESP: rsp_valid=1 for exactly one cycle with rsp_rdata/rsp_error; next cycle IDLE, cmd_ready=1.
//  Minimum latency accept->rsp_valid: 3 cycles (ADDR, DATA, RESP) with zero wait states; rejected cmd: 1 cycle.
//  Each HREADY=0 cycle in ADDR or DATA adds one cycle. rsp_rdata/rsp_error hold value until next rsp_valid.
//  cmd_valid while cmd_ready=0 is ignored (not queued); cmd inputs sampled only at accept.
//  HRESET mid-transfer: immediate return to reset values, HTRANS=IDLE; aborted command produces no response.
// TESTING
//  1 Word write 0x5000_0000 data 0xA5 zero waits -> NONSEQ 1 cycle, HWDATA=0x0000_00A5, rsp_valid 3 cyc after accept, err=0.
//  2 Byte read addr 0x5000_0003, HRDATA=0xCD00_0000, 2 data-phase waits -> rsp_rdata=0x0000_00CD, latency 5.
//  3 Half write addr 0x...02 data 0x1234 -> HWDATA=0x1234_0000, HSIZE=1; address held through 1 HREADY=0 in ADDR.
//  4 Two-cycle ERROR (HRESP=1 HREADY=0, then HRESP=1 HREADY=1) on read -> rsp_error=1, rsp_rdata=0, back to IDLE.
//  5 Word cmd addr 0x...01, ALIGN_CHECK=1 -> HTRANS stays IDLE, rsp_valid+rsp_error next cycle.
//  6 Assert HRESET in DATA with HREADY=0 -> all outputs reset values same cycle, no rsp_valid, next cmd works.

Source files
------------

// File: rtl/ahb_lite_single_master_if.sv
// Command/response and AHB-Lite signal bundle for the single-master initiator.
// cmd_*: a command transfers on a rising edge where cmd_valid && cmd_ready; rsp_* is a one-cycle pulse with no back-pressure.
interface ahb_lite_single_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, HRDATA, HREADY, HRESP,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, HRDATA, HREADY, HRESP,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
    );
endinterface

// File: rtl/ahb_lite_single_master.sv
// AHB-Lite initiator: one SINGLE NONSEQ transfer per accepted command, little-endian lane steering,
// response pulse on completion. All outputs come straight from registers.
module ahb_lite_single_master #(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic                             HCLK,
    input  logic                             HRESET,
    ahb_lite_single_master_if.master         bus,
    output logic [1:0]                       dbg_state_o
);
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_e;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    state_e      state_q;
    logic        cmd_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_error_q;
    logic [31:0] haddr_q;
    logic [1:0]  htrans_q;
    logic        hwrite_q;
    logic [2:0]  hsize_q;
    logic [31:0] hwdata_q;
    logic [31:0] wdata_q;

    logic        illegal_cmd;
    logic [31:0] hwdata_d;
    logic [31:0] rd_byte;
    logic [31:0] rd_half;
    logic [31:0] rdata_d;

    assign illegal_cmd = (bus.cmd_size > 3'd2)
                      || (bus.cmd_size == 3'd1 && bus.cmd_addr[0])
                      || (bus.cmd_size == 3'd2 && bus.cmd_addr[1:0] != 2'b00);

    assign rd_byte = bus.HRDATA >> {haddr_q[1:0], 3'b000};
    assign rd_half = bus.HRDATA >> {haddr_q[1], 4'b0000};

    // Write data moves from the LSBs onto its lane; read data comes back down and is zero-extended.
    always_comb begin
        hwdata_d = wdata_q;
        rdata_d  = bus.HRDATA;
        case (hsize_q)
            3'd0: begin
                hwdata_d = {24'b0, wdata_q[7:0]} << {haddr_q[1:0], 3'b000};
                rdata_d  = {24'b0, rd_byte[7:0]};
            end
            3'd1: begin
                hwdata_d = {16'b0, wdata_q[15:0]} << {haddr_q[1], 4'b0000};
                rdata_d  = {16'b0, rd_half[15:0]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
            haddr_q     <= '0;
            htrans_q    <= TRANS_IDLE;
            hwrite_q    <= 1'b0;
            hsize_q     <= '0;
            hwdata_q    <= '0;
            wdata_q     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        wdata_q     <= bus.cmd_wdata;
                        if (ALIGN_CHECK && illegal_cmd) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_error_q <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            state_q  <= S_ADDR;
                            haddr_q  <= bus.cmd_addr;
                            hwrite_q <= bus.cmd_write;
                            hsize_q  <= bus.cmd_size;
                            htrans_q <= TRANS_NONSEQ;
                        end
                    end
                end
                S_ADDR: begin
                    if (bus.HREADY) begin
                        state_q  <= S_DATA;
                        htrans_q <= TRANS_IDLE;
                        hwdata_q <= hwrite_q ? hwdata_d : '0;
                    end
                end
                S_DATA: begin
                    // An HRESP=1 cycle with HREADY=0 is only the first half of an ERROR response.
                    if (bus.HREADY) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= bus.HRESP;
                        rsp_rdata_q <= (!hwrite_q && !bus.HRESP) ? rdata_d : '0;
                    end
                end
                S_RESP: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;
    assign bus.HADDR     = haddr_q;
    assign bus.HTRANS    = htrans_q;
    assign bus.HWRITE    = hwrite_q;
    assign bus.HSIZE     = hsize_q;
    assign bus.HBURST    = 3'b000;
    assign bus.HWDATA    = hwdata_q;
    assign dbg_state_o   = state_q;
endmodule
